// File: rtl/baseline_subtract_mc_if.sv
// rtl/baseline_subtract_mc_if.sv - stream and control bundle for baseline_subtract_mc
//
// Purpose: carries the configuration inputs, the raw/upper/lower input streams,
// the result stream and the status outputs of baseline_subtract_mc.
// Modports:
//   master - the environment: drives cfg_*, sat_clear, the three input
//            streams and out_tready; observes the treadys, the result stream,
//            sat_flag and fifo_level.
//   slave  - the combiner itself, the mirror image of master.
// Channel c of every tdata bus occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
interface baseline_subtract_mc_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_CHANNELS = 2,
  parameter int FIFO_DEPTH   = 256,
  parameter int SKIP_WIDTH   = 8
);
  localparam int W  = NUM_CHANNELS * DATA_WIDTH;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic                    cfg_enable;
  logic [1:0]              cfg_mode;
  logic [SKIP_WIDTH-1:0]   cfg_skip;
  logic                    sat_clear;

  logic [W-1:0]            raw_tdata;
  logic                    raw_tvalid;
  logic                    raw_tready;

  logic [W-1:0]            up_tdata;
  logic                    up_tvalid;
  logic                    up_tready;

  logic [W-1:0]            lo_tdata;
  logic                    lo_tvalid;
  logic                    lo_tready;

  logic [W-1:0]            out_tdata;
  logic                    out_tvalid;
  logic                    out_tready;

  logic [NUM_CHANNELS-1:0] sat_flag;
  logic [LW-1:0]           fifo_level;

  modport master (
    output cfg_enable, cfg_mode, cfg_skip, sat_clear,
    output raw_tdata, raw_tvalid, up_tdata, up_tvalid, lo_tdata, lo_tvalid,
    output out_tready,
    input  raw_tready, up_tready, lo_tready,
    input  out_tdata, out_tvalid, sat_flag, fifo_level
  );

  modport slave (
    input  cfg_enable, cfg_mode, cfg_skip, sat_clear,
    input  raw_tdata, raw_tvalid, up_tdata, up_tvalid, lo_tdata, lo_tvalid,
    input  out_tready,
    output raw_tready, up_tready, lo_tready,
    output out_tdata, out_tvalid, sat_flag, fifo_level
  );
endinterface

// File: rtl/baseline_subtract_mc.sv
// rtl/baseline_subtract_mc.sv - multichannel FIFO-aligned baseline subtractor
//
// Purpose: queues raw samples in a FIFO (after discarding cfg_skip leading
// samples), joins each queued sample with one upper/lower baseline pair, forms
// a mode-selected baseline per channel, and emits the saturated difference
// through a two-stage, fully back-pressured output pipeline.
// Ports:
//   clk       - clock
//   areset_n  - asynchronous active-low reset
//   bus       - baseline_subtract_mc_if.slave: cfg_enable/cfg_mode/cfg_skip,
//               sat_clear, raw/up/lo input streams, out result stream,
//               sat_flag (sticky per channel) and fifo_level (occupancy)
module baseline_subtract_mc #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_CHANNELS = 2,
  parameter int FIFO_DEPTH   = 256,
  parameter int SKIP_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  areset_n,
  baseline_subtract_mc_if.slave bus
);
  localparam int W  = NUM_CHANNELS * DATA_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, SKIP, RUN} state_t;

  state_t                  state_q, state_d;
  logic [SKIP_WIDTH-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]           level_q, level_d;
  logic [W-1:0]            mem [FIFO_DEPTH];

  logic                    s1_valid_q;
  logic [W-1:0]            s1_raw_q, s1_base_q;
  logic                    out_valid_q;
  logic [W-1:0]            out_data_q;
  logic [NUM_CHANNELS-1:0] sat_q, sat_d;

  logic                    raw_ready;
  logic                    fifo_empty, fifo_full;
  logic                    push, join_fire;
  logic                    s1_accept, s2_accept;
  logic [W-1:0]            base_d, diff_sat;
  logic [NUM_CHANNELS-1:0] sat_vec;

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LW'(FIFO_DEPTH));

  // Each stage advances when the register below it is empty or draining.
  assign s2_accept = !out_valid_q || bus.out_tready;
  assign s1_accept = !s1_valid_q || s2_accept;

  assign push      = (state_q == RUN) && bus.raw_tvalid && !fifo_full;
  assign join_fire = (state_q == RUN) && !fifo_empty && bus.up_tvalid &&
                     bus.lo_tvalid && s1_accept;

  // Control FSM: next state, skip counter and raw_tready.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    raw_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cfg_enable) begin
          if (bus.cfg_skip == '0) begin
            state_d = RUN;
          end else begin
            state_d = SKIP;
            cnt_d   = bus.cfg_skip;
          end
        end
      end
      SKIP: begin
        raw_ready = 1'b1;
        if (bus.raw_tvalid) begin
          cnt_d = cnt_q - SKIP_WIDTH'(1);
          if (cnt_q == SKIP_WIDTH'(1)) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        raw_ready = !fifo_full;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (!bus.cfg_enable) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    level_d = level_q + LW'(push) - LW'(join_fire);
    sat_d   = sat_q;
    if (bus.cfg_enable && s2_accept && s1_valid_q) begin
      sat_d = sat_q | sat_vec;
    end
    // Clearing wins over a set landing in the same cycle.
    if (bus.sat_clear) begin
      sat_d = '0;
    end
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    logic signed [DATA_WIDTH-1:0] up_c, lo_c, base_c;
    logic signed [DATA_WIDTH-1:0] s1_raw_c, s1_base_c, res_c;
    logic        [DATA_WIDTH:0]   sum_c;
    logic        [DATA_WIDTH+1:0] diff_c;
    logic                         ovf_c;

    assign up_c  = bus.up_tdata[c*DATA_WIDTH +: DATA_WIDTH];
    assign lo_c  = bus.lo_tdata[c*DATA_WIDTH +: DATA_WIDTH];
    // One guard bit keeps the sum exact; dropping its LSB is an arithmetic
    // shift right, i.e. floor division by two.
    assign sum_c = {up_c[DATA_WIDTH-1], up_c} + {lo_c[DATA_WIDTH-1], lo_c};

    always_comb begin
      base_c = '0;
      case (bus.cfg_mode)
        2'd0:    base_c = sum_c[DATA_WIDTH:1];
        2'd1:    base_c = up_c;
        2'd2:    base_c = lo_c;
        default: base_c = '0;
      endcase
    end
    assign base_d[c*DATA_WIDTH +: DATA_WIDTH] = base_c;

    assign s1_raw_c  = s1_raw_q[c*DATA_WIDTH +: DATA_WIDTH];
    assign s1_base_c = s1_base_q[c*DATA_WIDTH +: DATA_WIDTH];
    assign diff_c    = {{2{s1_raw_c[DATA_WIDTH-1]}}, s1_raw_c} -
                       {{2{s1_base_c[DATA_WIDTH-1]}}, s1_base_c};
    // The result fits in DATA_WIDTH only if the top three bits agree.
    assign ovf_c = (diff_c[DATA_WIDTH+1:DATA_WIDTH-1] != 3'b000) &&
                   (diff_c[DATA_WIDTH+1:DATA_WIDTH-1] != 3'b111);
    assign res_c = !ovf_c ? diff_c[DATA_WIDTH-1:0] :
                   diff_c[DATA_WIDTH+1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} :
                                          {1'b0, {(DATA_WIDTH-1){1'b1}}};
    assign diff_sat[c*DATA_WIDTH +: DATA_WIDTH] = res_c;
    assign sat_vec[c] = ovf_c;
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      s1_valid_q  <= 1'b0;
      s1_raw_q    <= '0;
      s1_base_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sat_q       <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      if (!bus.cfg_enable) begin
        // Soft clear: everything queued or in flight is dropped.
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
        level_q     <= '0;
        s1_valid_q  <= 1'b0;
        out_valid_q <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr_q <= wr_ptr_q + AW'(1);
        end
        if (join_fire) begin
          rd_ptr_q <= rd_ptr_q + AW'(1);
        end
        level_q <= level_d;
        if (s1_accept) begin
          s1_valid_q <= join_fire;
          if (join_fire) begin
            s1_raw_q  <= mem[rd_ptr_q];
            s1_base_q <= base_d;
          end
        end
        if (s2_accept) begin
          out_valid_q <= s1_valid_q;
          if (s1_valid_q) begin
            out_data_q <= diff_sat;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && bus.cfg_enable) begin
      mem[wr_ptr_q] <= bus.raw_tdata;
    end
  end

  assign bus.raw_tready = raw_ready;
  assign bus.up_tready  = join_fire;
  assign bus.lo_tready  = join_fire;
  assign bus.out_tdata  = out_data_q;
  assign bus.out_tvalid = out_valid_q;
  assign bus.sat_flag   = sat_q;
  assign bus.fifo_level = level_q;
endmodule

// File: tb/tb_baseline_subtract_mc.sv
// tb/tb_baseline_subtract_mc.sv - self-checking bench for baseline_subtract_mc
module tb_baseline_subtract_mc;
  localparam int DW = 16;
  localparam int NC = 2;
  localparam int FD = 4;
  localparam int SW = 8;
  localparam int W  = DW * NC;

  logic clk = 1'b0;
  logic areset_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  baseline_subtract_mc_if #(.DATA_WIDTH(DW), .NUM_CHANNELS(NC), .FIFO_DEPTH(FD), .SKIP_WIDTH(SW)) bus ();

  baseline_subtract_mc #(.DATA_WIDTH(DW), .NUM_CHANNELS(NC), .FIFO_DEPTH(FD), .SKIP_WIDTH(SW)) dut (
    .clk(clk), .areset_n(areset_n), .bus(bus)
  );

  logic [W-1:0] st_raw[$], st_up[$], st_lo[$], got_q[$];
  int           st_mode[$];
  int           stall_bad, stall_seen;
  bit           timed_out;

  // Reference: baseline and saturated difference from plain integer arithmetic.
  function automatic logic [W-1:0] model(input logic [W-1:0] raw, input logic [W-1:0] up,
                                         input logic [W-1:0] lo, input int mode,
                                         output logic [NC-1:0] sat);
    logic [W-1:0] r;
    logic [DW-1:0] t;
    int rv, uv, lv, s, base, d;
    r = '0;
    sat = '0;
    for (int c = 0; c < NC; c++) begin
      t = raw[c*DW +: DW]; rv = $signed(t);
      t = up[c*DW +: DW];  uv = $signed(t);
      t = lo[c*DW +: DW];  lv = $signed(t);
      s = uv + lv;
      case (mode)
        0: base = (s >= 0) ? s / 2 : -((1 - s) / 2);
        1: base = uv;
        2: base = lv;
        default: base = 0;
      endcase
      d = rv - base;
      if (d > 32767) begin d = 32767; sat[c] = 1'b1; end
      if (d < -32768) begin d = -32768; sat[c] = 1'b1; end
      r[c*DW +: DW] = d[DW-1:0];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] w;
    for (int c = 0; c < NC; c++) begin
      case ($urandom_range(3, 0))
        0: w[c*DW +: DW] = 16'h7fff;
        1: w[c*DW +: DW] = 16'h8000;
        default: w[c*DW +: DW] = DW'($urandom);
      endcase
    end
    return w;
  endfunction

  task automatic soft_clear(input int skip);
    bus.cfg_enable = 1'b0;
    bus.sat_clear  = 1'b1;
    @(posedge clk); #1;
    bus.sat_clear  = 1'b0;
    bus.cfg_skip   = SW'(skip);
    bus.cfg_enable = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic push_raw(input logic [W-1:0] d, output bit to);
    int k;
    to = 0; k = 0;
    bus.raw_tdata = d; bus.raw_tvalid = 1'b1;
    @(negedge clk);
    while (!bus.raw_tready && k < 500) begin @(negedge clk); k++; end
    if (k >= 500) to = 1;
    @(posedge clk); #1;
    bus.raw_tvalid = 1'b0;
  endtask

  // Drives the st_* queues concurrently and collects results into got_q.
  task automatic run_stream(input int rdy_mode, input int max_gap);
    int n;
    n = st_raw.size();
    got_q.delete(); stall_bad = 0; stall_seen = 0; timed_out = 0;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          int k;
          repeat ($urandom_range(max_gap, 0)) begin @(posedge clk); #1; end
          bus.raw_tdata = st_raw[i]; bus.raw_tvalid = 1'b1; k = 0;
          @(negedge clk);
          while (!bus.raw_tready && k < 1000) begin @(negedge clk); k++; end
          if (k >= 1000) timed_out = 1;
          @(posedge clk); #1;
          bus.raw_tvalid = 1'b0;
        end
      end
      begin
        for (int j = 0; j < n; j++) begin
          int k;
          repeat ($urandom_range(max_gap, 0)) begin @(posedge clk); #1; end
          bus.up_tdata = st_up[j]; bus.lo_tdata = st_lo[j]; bus.cfg_mode = 2'(st_mode[j]);
          bus.up_tvalid = 1'b1; bus.lo_tvalid = 1'b1; k = 0;
          @(negedge clk);
          while (!bus.up_tready && k < 1000) begin @(negedge clk); k++; end
          if (k >= 1000 || !bus.lo_tready) timed_out = 1;
          @(posedge clk); #1;
          bus.up_tvalid = 1'b0; bus.lo_tvalid = 1'b0;
        end
      end
      begin
        int cyc;
        bit pend;
        logic [W-1:0] held;
        cyc = 0; pend = 0; held = '0;
        while (got_q.size() < n && cyc < 4000) begin
          case (rdy_mode)
            0: bus.out_tready = 1'b1;
            1: bus.out_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: bus.out_tready = 1'($urandom_range(1, 0));
          endcase
          @(negedge clk);
          if (pend && (!bus.out_tvalid || bus.out_tdata !== held)) stall_bad++;
          pend = 0;
          if (bus.out_tvalid) begin
            if (bus.out_tready) got_q.push_back(bus.out_tdata);
            else begin pend = 1; held = bus.out_tdata; stall_seen++; end
          end
          @(posedge clk); #1;
          cyc++;
        end
        if (cyc >= 4000) timed_out = 1;
        bus.out_tready = 1'b0;
      end
    join
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus.out_tvalid !== 1'b0) begin failures++; $display("FAIL reset_out_tvalid got=%0b exp=0", bus.out_tvalid); end
    checks++; if (bus.out_tdata !== '0) begin failures++; $display("FAIL reset_out_tdata got=%h exp=0", bus.out_tdata); end
    checks++; if (bus.raw_tready !== 1'b0) begin failures++; $display("FAIL reset_raw_tready got=%0b exp=0", bus.raw_tready); end
    checks++; if (bus.up_tready !== 1'b0) begin failures++; $display("FAIL reset_up_tready got=%0b exp=0", bus.up_tready); end
    checks++; if (bus.fifo_level !== '0) begin failures++; $display("FAIL reset_fifo_level got=%0d exp=0", bus.fifo_level); end
    checks++; if (bus.sat_flag !== '0) begin failures++; $display("FAIL reset_sat_flag got=%b exp=0", bus.sat_flag); end
  endtask

  task automatic test_skip_align();
    logic [W-1:0] raws[5];
    logic [W-1:0] up, lo, exp;
    logic [NC-1:0] s;
    bit to;
    bus.cfg_mode = 2'd0; bus.cfg_skip = SW'(3); bus.cfg_enable = 1'b1; bus.out_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      raws[i] = rnd_word();
      raws[i][DW-1:0] = DW'(10 * (i + 1));
      push_raw(raws[i], to);
      checks++; if (to !== 1'b0) begin failures++; $display("FAIL skip_push_timeout idx=%0d", i); end
    end
    @(negedge clk);
    checks++; if (bus.fifo_level !== 3'd2) begin failures++; $display("FAIL skip_level got=%0d exp=2", bus.fifo_level); end
    @(posedge clk); #1;
    up = rnd_word(); up[DW-1:0] = 16'd8;
    lo = rnd_word(); lo[DW-1:0] = 16'd4;
    exp = model(raws[3], up, lo, 0, s);
    bus.up_tdata = up; bus.lo_tdata = lo; bus.up_tvalid = 1'b1; bus.lo_tvalid = 1'b1;
    @(negedge clk);
    checks++; if (bus.up_tready !== 1'b1 || bus.lo_tready !== 1'b1) begin failures++; $display("FAIL skip_join got=%0b%0b exp=11", bus.up_tready, bus.lo_tready); end
    @(posedge clk); #1;
    bus.up_tvalid = 1'b0; bus.lo_tvalid = 1'b0;
    @(negedge clk);
    checks++; if (bus.out_tvalid !== 1'b0) begin failures++; $display("FAIL skip_latency_early got=%0b exp=0", bus.out_tvalid); end
    checks++; if (bus.fifo_level !== 3'd1) begin failures++; $display("FAIL skip_level_after_join got=%0d exp=1", bus.fifo_level); end
    @(negedge clk);
    checks++; if (bus.out_tvalid !== 1'b1) begin failures++; $display("FAIL skip_latency got=%0b exp=1", bus.out_tvalid); end
    checks++; if (bus.out_tdata[DW-1:0] !== 16'd34) begin failures++; $display("FAIL skip_ch0 got=%0d exp=34", $signed(bus.out_tdata[DW-1:0])); end
    checks++; if (bus.out_tdata !== exp) begin failures++; $display("FAIL skip_word got=%h exp=%h", bus.out_tdata, exp); end
    @(posedge clk); #1;
  endtask

  task automatic test_modes();
    int rv[4] = '{0, 100, 100, -7};
    int uv[4] = '{-3, 30, 5, 9};
    int lv[4] = '{0, 11, 130, -4};
    int ev[4] = '{2, 70, -30, -7};
    logic [W-1:0] w, exp;
    logic [NC-1:0] s;
    soft_clear(0);
    st_raw.delete(); st_up.delete(); st_lo.delete(); st_mode.delete();
    for (int i = 0; i < 4; i++) begin
      w = rnd_word(); w[DW-1:0] = DW'(rv[i]); st_raw.push_back(w);
      w = rnd_word(); w[DW-1:0] = DW'(uv[i]); st_up.push_back(w);
      w = rnd_word(); w[DW-1:0] = DW'(lv[i]); st_lo.push_back(w);
      st_mode.push_back(i);
    end
    run_stream(0, 0);
    checks++; if (timed_out !== 1'b0 || got_q.size() != 4) begin failures++; $display("FAIL modes_count got=%0d exp=4 timeout=%0b", got_q.size(), timed_out); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      exp = model(st_raw[i], st_up[i], st_lo[i], i, s);
      checks++; if (got_q[i][DW-1:0] !== DW'(ev[i])) begin failures++; $display("FAIL mode%0d_ch0 got=%0d exp=%0d", i, $signed(got_q[i][DW-1:0]), ev[i]); end
      checks++; if (got_q[i] !== exp) begin failures++; $display("FAIL mode%0d_word got=%h exp=%h", i, got_q[i], exp); end
    end
    @(negedge clk);
    checks++; if (bus.fifo_level !== '0) begin failures++; $display("FAIL modes_level got=%0d exp=0", bus.fifo_level); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    bit to;
    soft_clear(0);
    st_raw.delete(); st_up.delete(); st_lo.delete(); st_mode.delete();
    st_raw.push_back({16'd0, 16'h7fff}); st_up.push_back({16'd0, 16'hffff});
    st_lo.push_back(32'h0); st_mode.push_back(1);
    run_stream(0, 0);
    checks++; if (got_q.size() != 1 || got_q[0] !== {16'd0, 16'h7fff}) begin failures++; $display("FAIL sat_value got_n=%0d exp=00007fff", got_q.size()); end
    @(negedge clk);
    checks++; if (bus.sat_flag !== 2'b01) begin failures++; $display("FAIL sat_flag_set got=%b exp=01", bus.sat_flag); end
    @(posedge clk); #1;
    push_raw({16'd0, 16'h7fff}, to);
    bus.up_tdata = {16'd0, 16'hffff}; bus.lo_tdata = '0; bus.cfg_mode = 2'd1;
    bus.up_tvalid = 1'b1; bus.lo_tvalid = 1'b1; bus.sat_clear = 1'b1; bus.out_tready = 1'b1;
    @(negedge clk);
    checks++; if (bus.up_tready !== 1'b1 || to !== 1'b0) begin failures++; $display("FAIL sat_join got=%0b exp=1", bus.up_tready); end
    @(posedge clk); #1;
    bus.up_tvalid = 1'b0; bus.lo_tvalid = 1'b0;
    @(posedge clk); #1;
    bus.sat_clear = 1'b0;
    @(negedge clk);
    checks++; if (bus.out_tvalid !== 1'b1 || bus.out_tdata !== {16'd0, 16'h7fff}) begin failures++; $display("FAIL sat_second_out got=%0b/%h exp=1/00007fff", bus.out_tvalid, bus.out_tdata); end
    checks++; if (bus.sat_flag !== 2'b00) begin failures++; $display("FAIL sat_clear_priority got=%b exp=00", bus.sat_flag); end
    @(posedge clk); #1;
    bus.out_tready = 1'b0;
    @(negedge clk);
    checks++; if (bus.sat_flag !== 2'b00) begin failures++; $display("FAIL sat_clear_hold got=%b exp=00", bus.sat_flag); end
    @(posedge clk); #1;
  endtask

  task automatic fill_random(input int n);
    st_raw.delete(); st_up.delete(); st_lo.delete(); st_mode.delete();
    for (int i = 0; i < n; i++) begin
      st_raw.push_back(rnd_word()); st_up.push_back(rnd_word()); st_lo.push_back(rnd_word());
      st_mode.push_back($urandom_range(3, 0));
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] exp;
    logic [NC-1:0] s;
    soft_clear(0);
    fill_random(10);
    run_stream(1, 0);
    checks++; if (timed_out !== 1'b0 || got_q.size() != 10) begin failures++; $display("FAIL bp_count got=%0d exp=10 timeout=%0b", got_q.size(), timed_out); end
    for (int i = 0; i < 10 && i < got_q.size(); i++) begin
      exp = model(st_raw[i], st_up[i], st_lo[i], st_mode[i], s);
      checks++; if (got_q[i] !== exp) begin failures++; $display("FAIL bp_data idx=%0d got=%h exp=%h", i, got_q[i], exp); end
    end
    checks++; if (stall_bad != 0) begin failures++; $display("FAIL bp_stall_stable got=%0d exp=0", stall_bad); end
    checks++; if (stall_seen == 0) begin failures++; $display("FAIL bp_stalls_seen got=0 exp>0"); end
  endtask

  task automatic test_fifo_full_and_soft_clear();
    int pushed;
    logic [W-1:0] exp;
    logic [NC-1:0] s;
    soft_clear(0);
    pushed = 0; bus.out_tready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.raw_tdata = rnd_word(); bus.raw_tvalid = 1'b1;
      @(negedge clk);
      if (bus.raw_tready) pushed++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++; if (bus.fifo_level !== 3'd4) begin failures++; $display("FAIL full_level got=%0d exp=4", bus.fifo_level); end
    checks++; if (bus.raw_tready !== 1'b0) begin failures++; $display("FAIL full_raw_tready got=%0b exp=0", bus.raw_tready); end
    checks++; if (pushed != 4) begin failures++; $display("FAIL full_pushed got=%0d exp=4", pushed); end
    @(posedge clk); #1;
    bus.raw_tvalid = 1'b0;
    bus.cfg_mode = 2'd3; bus.up_tvalid = 1'b1; bus.lo_tvalid = 1'b1;
    @(posedge clk); #1;
    bus.up_tvalid = 1'b0; bus.lo_tvalid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bus.out_tvalid !== 1'b1 || bus.fifo_level !== 3'd3) begin failures++; $display("FAIL clear_setup got=%0b/%0d exp=1/3", bus.out_tvalid, bus.fifo_level); end
    @(posedge clk); #1;
    bus.cfg_enable = 1'b0;
    @(posedge clk); #1;
    bus.cfg_skip = '0; bus.cfg_enable = 1'b1;
    @(negedge clk);
    checks++; if (bus.out_tvalid !== 1'b0) begin failures++; $display("FAIL clear_out_tvalid got=%0b exp=0", bus.out_tvalid); end
    checks++; if (bus.fifo_level !== '0) begin failures++; $display("FAIL clear_level got=%0d exp=0", bus.fifo_level); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bus.raw_tready !== 1'b1) begin failures++; $display("FAIL reenable_raw_tready got=%0b exp=1", bus.raw_tready); end
    @(posedge clk); #1;
    fill_random(3);
    run_stream(0, 1);
    checks++; if (timed_out !== 1'b0 || got_q.size() != 3) begin failures++; $display("FAIL reenable_count got=%0d exp=3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      exp = model(st_raw[i], st_up[i], st_lo[i], st_mode[i], s);
      checks++; if (got_q[i] !== exp) begin failures++; $display("FAIL reenable_data idx=%0d got=%h exp=%h", i, got_q[i], exp); end
    end
  endtask

  task automatic test_random_stream();
    logic [W-1:0] exp;
    logic [NC-1:0] s, flags;
    int errs;
    soft_clear(0);
    fill_random(40);
    st_raw[0] = {16'h8000, 16'h7fff}; st_up[0] = {16'h7fff, 16'h8000}; st_mode[0] = 1;
    run_stream(2, 2);
    checks++; if (timed_out !== 1'b0 || got_q.size() != 40) begin failures++; $display("FAIL rand_count got=%0d exp=40 timeout=%0b", got_q.size(), timed_out); end
    flags = '0; errs = 0;
    for (int i = 0; i < 40; i++) begin
      exp = model(st_raw[i], st_up[i], st_lo[i], st_mode[i], s);
      flags |= s;
      if (i < got_q.size()) begin
        checks++; if (got_q[i] !== exp) begin failures++; errs++; if (errs < 5) $display("FAIL rand_data idx=%0d got=%h exp=%h", i, got_q[i], exp); end
      end
    end
    checks++; if (stall_bad != 0) begin failures++; $display("FAIL rand_stall_stable got=%0d exp=0", stall_bad); end
    @(negedge clk);
    checks++; if (bus.sat_flag !== flags) begin failures++; $display("FAIL rand_sat_flag got=%b exp=%b", bus.sat_flag, flags); end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    bit to;
    bus.out_tready = 1'b0; bus.cfg_mode = 2'd3;
    push_raw(rnd_word(), to);
    push_raw(rnd_word(), to);
    bus.up_tvalid = 1'b1; bus.lo_tvalid = 1'b1;
    @(posedge clk); #1;
    bus.up_tvalid = 1'b0; bus.lo_tvalid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bus.out_tvalid !== 1'b1 || bus.sat_flag === '0) begin failures++; $display("FAIL arst_setup got=%0b/%b exp=1/nonzero", bus.out_tvalid, bus.sat_flag); end
    @(posedge clk); #1;
    #1 areset_n = 1'b0;
    #1;
    checks++; if (bus.out_tvalid !== 1'b0 || bus.out_tdata !== '0) begin failures++; $display("FAIL arst_out got=%0b/%h exp=0/0", bus.out_tvalid, bus.out_tdata); end
    checks++; if (bus.fifo_level !== '0 || bus.sat_flag !== '0) begin failures++; $display("FAIL arst_status got=%0d/%b exp=0/0", bus.fifo_level, bus.sat_flag); end
    #1 areset_n = 1'b1;
    #1;
    checks++; if (bus.raw_tready !== 1'b0 || bus.up_tready !== 1'b0) begin failures++; $display("FAIL arst_idle got=%0b%0b exp=00", bus.raw_tready, bus.up_tready); end
    @(negedge clk);
    checks++; if (bus.raw_tready !== 1'b1) begin failures++; $display("FAIL arst_to_run got=%0b exp=1", bus.raw_tready); end
  endtask

  initial begin
    bus.cfg_enable = 1'b0; bus.cfg_mode = 2'd0; bus.cfg_skip = '0; bus.sat_clear = 1'b0;
    bus.raw_tdata = '0; bus.raw_tvalid = 1'b0;
    bus.up_tdata = '0; bus.up_tvalid = 1'b0;
    bus.lo_tdata = '0; bus.lo_tvalid = 1'b0;
    bus.out_tready = 1'b0;
    areset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 areset_n = 1'b1;
    test_reset();
    @(posedge clk); #1;
    test_skip_align();
    test_modes();
    test_saturation();
    test_backpressure();
    test_fifo_full_and_soft_clear();
    test_random_stream();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/baseline_subtract_mc.md
Name: baseline_subtract_mc

Overview:
- Multichannel, parametrised successor to the single-channel baseline-subtract combiner.
- Buffers the raw sample stream in an internal FIFO and aligns it with externally generated upper/lower morphological baseline streams, dropping a programmable number of leading raw samples.
- Forms a mode-selected baseline, subtracts it with saturation, and drives a fully back-pressured AXI-Stream output.
- Sits between the upper/lower baseline engines and the downstream consumer.

Parameters:
- DATA_WIDTH, 16, signed sample width per channel.
- NUM_CHANNELS, 2, channels packed side by side in tdata; channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- FIFO_DEPTH, 256, raw FIFO entries; power of two, at least 2.
- SKIP_WIDTH, 8, width of cfg_skip.

Ports:
- clk  in  1  clock.
- areset_n  in  1  asynchronous active-low reset.
- cfg_enable  in  1  1 = run; 0 = synchronous soft clear.
- cfg_mode  in  2  0 avg, 1 upper, 2 lower, 3 bypass.
- cfg_skip  in  SKIP_WIDTH  leading raw samples to discard after enable.
- sat_clear  in  1  clears sat_flag.
- raw_tdata  in  NUM_CHANNELS*DATA_WIDTH  raw samples.
- raw_tvalid  in  1.
- raw_tready  out  1.
- up_tdata  in  NUM_CHANNELS*DATA_WIDTH  upper baseline.
- up_tvalid  in  1.
- up_tready  out  1.
- lo_tdata  in  NUM_CHANNELS*DATA_WIDTH  lower baseline.
- lo_tvalid  in  1.
- lo_tready  out  1.
- out_tdata  out  NUM_CHANNELS*DATA_WIDTH  result.
- out_tvalid  out  1.
- out_tready  in  1.
- sat_flag  out  NUM_CHANNELS  sticky per-channel saturation.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  raw FIFO occupancy.

Behaviour:
- Reset is asynchronous, active-low, on clk.
  - Reset values: all outputs 0, FIFO empty, state IDLE, pipeline valids 0.
- FSM states are IDLE, SKIP and RUN.
  - IDLE: all treadys 0. cfg_enable=1 goes to SKIP with cnt=cfg_skip, or directly to RUN if cfg_skip=0.
  - SKIP: raw_tready=1 and up/lo_tready=0. Each raw handshake decrements cnt and the sample is discarded. The handshake that takes cnt to 0 moves the FSM to RUN.
  - RUN: raw_tready = FIFO not full. Every raw handshake is written to the FIFO.
  - cfg_enable=0 in any state: next cycle returns to IDLE, empties the FIFO, zeroes pipeline valids and out_tvalid. Data in flight is dropped. sat_flag is kept.
- Join condition (RUN only), all required in the same cycle:
  - FIFO non-empty, up_tvalid, lo_tvalid, and stage-1 accept (stage-1 empty or advancing).
  - up_tready = lo_tready = join.
  - The join pops one FIFO entry. There are no partial consumes.
  - up/lo are consumed in all modes, including bypass.
  - A simultaneous FIFO push and pop leaves fifo_level unchanged. A push into a full FIFO cannot occur because raw_tready=0 when full.
- Pipeline:
  - Stage 1 registers raw and base per channel.
    - Mode 0: base = (up+lo)>>>1, computed at DATA_WIDTH+1 bits, floor rounding.
    - Mode 1: base = up.
    - Mode 2: base = lo.
    - Mode 3: base = 0.
  - Stage 2 (output register) holds diff = raw - base at DATA_WIDTH+2 bits, saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
    - A saturating channel sets sat_flag[c] in the cycle the stage-2 register loads.
  - Latency: a join in cycle t gives out_tvalid=1 in cycle t+2.
  - A stage advances when its downstream register is empty or out_tready=1. Full throughput is one result per cycle. out_tdata is held stable while out_tvalid=1 and out_tready=0.
- sat_flag:
  - sat_clear has priority over a same-cycle set, so the flag is 0 next cycle.
  - Flags are sticky otherwise.
- cfg_mode is sampled at the join cycle.
  - A change mid-stream affects only later joins.
- FIFO read/write pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Skip and align, mode 0, cfg_skip=3, NUM_CHANNELS=2: raw ch0 = 10,20,30,40,50; then up=8, lo=4 -> samples 10,20,30 dropped; first out ch0 = 40-6 = 34 at join+2; fifo_level reads 1 after that join.
- Mode 0, odd sum: raw=0, up=-3, lo=0 -> base = -2 (floor), out = 2. Mode 1: raw=100, up=30 -> 70. Mode 2: raw=100, lo=130 -> -30. Mode 3: raw=-7 -> -7 and up/lo are still consumed.
- Saturation, DATA_WIDTH=16, mode 1: raw=32767, up=-1 -> out 32767, sat_flag[0]=1, ch1 flag stays 0. Then assert sat_clear together with another saturating result -> flag reads 0 next cycle.
- Backpressure: 10-sample burst with out_tready toggled 1,0,0,1 -> no loss or duplication, tdata stable during stalls, outputs in order. FIFO_DEPTH=4 with baselines stalled -> raw_tready=0 when fifo_level=4.
- Soft clear mid-stream: deassert cfg_enable with 3 entries queued and out_tvalid=1 -> next cycle out_tvalid=0, fifo_level=0. Re-enable with cfg_skip=0 -> RUN directly, fresh alignment.
- Async reset mid-burst: areset_n low for a partial cycle -> all outputs 0 immediately, and the state is IDLE after release.
